// File: rtl/zeroriscy_mem_arbiter.sv
// rtl/zeroriscy_mem_arbiter.sv - two-master arbiter onto one SRAM req/gnt/rvalid port (option: MEM_ARB_RR_EN selects round-robin)
module zeroriscy_mem_arbiter #(
  parameter logic [10:0] WIN_TAG  = 11'h400,
  parameter int unsigned RESP_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        s_req,
  output logic        s_we,
  output logic [3:0]  s_be,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_gnt,
  input  logic        s_rvalid,
  input  logic [31:0] s_rdata,
  input  logic        s_err
);

  // Only a one-cycle SRAM response is supported by the response tag.
  if (RESP_LAT != 1) begin : g_bad_lat
    $error("zeroriscy_mem_arbiter: only RESP_LAT == 1 is supported");
  end

  logic        lock_vld;
  logic        lock_own;
  logic        resp_vld;
  logic        resp_own;
  logic        resp_loc;
  logic        rst_q;
`ifdef MEM_ARB_RR_EN
  logic        rr_last;
`endif

  logic        sel;
  logic        sel_req;
  logic        sel_we;
  logic [3:0]  sel_be;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        hit;
  logic        grant;
  logic        rsp_fire;

  // Pick this cycle's master: a locked master keeps the port, otherwise the priority rule decides.
  always_comb begin
    sel = 1'b0;
    if (lock_vld) begin
      sel = lock_own;
    end else if (m0_req && m1_req) begin
`ifdef MEM_ARB_RR_EN
      sel = ~rr_last;
`else
      sel = 1'b0;
`endif
    end else if (m1_req) begin
      sel = 1'b1;
    end
  end

  assign sel_req   = sel ? m1_req   : m0_req;
  assign sel_we    = sel ? m1_we    : m0_we;
  assign sel_be    = sel ? m1_be    : m0_be;
  assign sel_addr  = sel ? m1_addr  : m0_addr;
  assign sel_wdata = sel ? m1_wdata : m0_wdata;

  // Out-of-window accesses are accepted locally and never reach the SRAM.
  assign hit   = (sel_addr[31:21] == WIN_TAG);
  assign grant = !rst && sel_req && (hit ? s_gnt : 1'b1);

  assign s_req   = !rst && sel_req && hit;
  assign s_we    = s_req && sel_we;
  assign s_be    = sel_be;
  assign s_addr  = sel_addr;
  assign s_wdata = sel_wdata;

  assign m0_gnt = grant && !sel;
  assign m1_gnt = grant && sel;

  // A local error answers unconditionally; an SRAM response needs s_rvalid.
  assign rsp_fire  = !rst && resp_vld && (resp_loc || s_rvalid);
  assign m0_rvalid = rsp_fire && !resp_own;
  assign m1_rvalid = rsp_fire && resp_own;
  assign m0_rdata  = (m0_rvalid && !resp_loc) ? s_rdata : 32'h0;
  assign m1_rdata  = (m1_rvalid && !resp_loc) ? s_rdata : 32'h0;
  assign m0_err    = m0_rvalid && (resp_loc || s_err);
  assign m1_err    = m1_rvalid && (resp_loc || s_err);

  // Lock a stalled master onto the port and tag each grant for response routing.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_vld <= 1'b0;
      lock_own <= 1'b0;
      resp_vld <= 1'b0;
      resp_own <= 1'b0;
      resp_loc <= 1'b0;
      rst_q    <= 1'b1;
    end else begin
      rst_q <= 1'b0;
      if (sel_req && hit && !s_gnt) begin
        lock_vld <= 1'b1;
        lock_own <= sel;
      end else if (grant) begin
        lock_vld <= 1'b0;
      end
      resp_vld <= grant;
      resp_own <= sel;
      resp_loc <= !hit;
    end
  end

`ifdef MEM_ARB_RR_EN
  // Remember the last granted master so simultaneous requests alternate.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last <= 1'b1;
    end else if (grant) begin
      rr_last <= sel;
    end
  end
`endif

  // An SRAM response with no outstanding SRAM request is a protocol error (reset edges excused).
  always_ff @(posedge clk) begin
    if (!rst && !rst_q && s_rvalid) begin
      assert (resp_vld && !resp_loc);
    end
  end

endmodule

// File: tb/tb_zeroriscy_mem_arbiter.sv
// tb/tb_zeroriscy_mem_arbiter.sv - self-checking bench for zeroriscy_mem_arbiter
`timescale 1ns/1ps
module tb_zeroriscy_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req, we;
  logic [3:0]  be [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [1:0]  gnt, rvalid, err;
  logic [31:0] rdata [2];
  logic        s_req, s_we, s_gnt, s_rvalid, s_err;
  logic [3:0]  s_be;
  logic [31:0] s_addr, s_wdata, s_rdata;

  bit   [31:0] sram_mem [256];
  logic        poke_en;
  logic [7:0]  poke_idx;
  logic [31:0] poke_val;
  logic        sram_err_next;

  int n_cmp;
  int n_bad;

  zeroriscy_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(req[0]), .m0_we(we[0]), .m0_be(be[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
    .m0_gnt(gnt[0]), .m0_rvalid(rvalid[0]), .m0_rdata(rdata[0]), .m0_err(err[0]),
    .m1_req(req[1]), .m1_we(we[1]), .m1_be(be[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
    .m1_gnt(gnt[1]), .m1_rvalid(rvalid[1]), .m1_rdata(rdata[1]), .m1_err(err[1]),
    .s_req(s_req), .s_we(s_we), .s_be(s_be), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_err(s_err)
  );

  // SRAM model: one-cycle response, byte-enabled writes, garbage data when idle.
  always @(posedge clk) begin
    s_rvalid <= s_req && s_gnt;
    s_rdata  <= (s_req && s_gnt) ? sram_mem[s_addr[9:2]] : $urandom;
    s_err    <= (s_req && s_gnt) ? sram_err_next : 1'($urandom_range(0, 1));
    if (s_req && s_gnt && s_we) begin
      for (int b = 0; b < 4; b++)
        if (s_be[b]) sram_mem[s_addr[9:2]][8*b +: 8] <= s_wdata[8*b +: 8];
    end
    if (poke_en) sram_mem[poke_idx] <= poke_val;
  end

  task automatic poke(input logic [7:0] idx, input logic [31:0] val);
    poke_idx = idx; poke_val = val; poke_en = 1'b1;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic do_reset();
    req = 2'b00; rst = 1'b1; s_gnt = 1'b1; sram_err_next = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    req = 2'b11; we = 2'b00; addr[0] = 32'h8000_0010; addr[1] = 32'h8000_0020;
    s_gnt = 1'b1; rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (gnt !== 2'b00) begin n_bad++; $display("FAIL reset_gnt: got %b want 00", gnt); end
      n_cmp++; if (rvalid !== 2'b00) begin n_bad++; $display("FAIL reset_rvalid: got %b want 00", rvalid); end
      n_cmp++; if (s_req !== 1'b0) begin n_bad++; $display("FAIL reset_s_req: got %b want 0", s_req); end
      n_cmp++; if ((rdata[0] | rdata[1]) !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h/%h want 0", rdata[0], rdata[1]); end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (gnt !== 2'b01) begin n_bad++; $display("FAIL reset_first_gnt: got %b want 01", gnt); end
    @(posedge clk); #1;
    req = 2'b00;
  endtask

  task automatic test_read();
    poke(8'd1, 32'hCAFE_F00D);
    do_reset();
    req = 2'b01; we[0] = 1'b0; be[0] = 4'hF; addr[0] = 32'h8010_0004;
    @(negedge clk);
    n_cmp++; if (gnt !== 2'b01) begin n_bad++; $display("FAIL read_gnt: got %b want 01", gnt); end
    n_cmp++; if (s_req !== 1'b1 || s_addr !== 32'h8010_0004) begin n_bad++; $display("FAIL read_s_req: got %b/%h want 1/80100004", s_req, s_addr); end
    @(posedge clk); #1;
    req = 2'b00;
    @(negedge clk);
    n_cmp++; if (rvalid !== 2'b01) begin n_bad++; $display("FAIL read_rvalid: got %b want 01", rvalid); end
    n_cmp++; if (rdata[0] !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL read_rdata: got %h want cafef00d", rdata[0]); end
    n_cmp++; if (err !== 2'b00) begin n_bad++; $display("FAIL read_err: got %b want 00", err); end
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    int exp_o;
    int prev;
    logic [31:0] exp_d;
    poke(8'd2, 32'hA0A0_0002);
    poke(8'd3, 32'hB1B1_0003);
    do_reset();
    we = 2'b00; addr[0] = 32'h8000_0008; addr[1] = 32'h8000_000C;
    prev = -1; exp_o = 0;
    for (int c = 0; c < 5; c++) begin
      req = (c < 4) ? 2'b11 : 2'b00;
      @(negedge clk);
      if (c < 4) begin
`ifdef MEM_ARB_RR_EN
        exp_o = c % 2;
`else
        exp_o = 0;
`endif
        n_cmp++; if (gnt !== (exp_o == 1 ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL contention_gnt c%0d: got %b want m%0d", c, gnt, exp_o); end
      end
      if (prev >= 0) begin
        exp_d = (prev == 1) ? 32'hB1B1_0003 : 32'hA0A0_0002;
        n_cmp++; if (rvalid !== (prev == 1 ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL contention_route c%0d: got %b want m%0d", c, rvalid, prev); end
        n_cmp++; if (rdata[prev] !== exp_d) begin n_bad++; $display("FAIL contention_rdata c%0d: got %h want %h", c, rdata[prev], exp_d); end
      end
      prev = (c < 4) ? exp_o : -1;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    poke(8'd4, 32'h4444_4444);
    do_reset();
    we = 2'b00; addr[0] = 32'h8000_0014; addr[1] = 32'h8000_0010;
    for (int c = 1; c <= 3; c++) begin
      req = (c == 1) ? 2'b10 : 2'b11;
      s_gnt = (c == 3);
      @(negedge clk);
      n_cmp++; if (gnt !== (c == 3 ? 2'b10 : 2'b00)) begin n_bad++; $display("FAIL stall_gnt c%0d: got %b", c, gnt); end
      n_cmp++; if (s_req !== 1'b1 || s_addr !== 32'h8000_0010) begin n_bad++; $display("FAIL stall_s_addr c%0d: got %b/%h want 1/80000010", c, s_req, s_addr); end
      @(posedge clk); #1;
    end
    req = 2'b01;
    @(negedge clk);
    n_cmp++; if (gnt !== 2'b01) begin n_bad++; $display("FAIL stall_m0_gnt: got %b want 01", gnt); end
    n_cmp++; if (rvalid !== 2'b10 || rdata[1] !== 32'h4444_4444) begin n_bad++; $display("FAIL stall_m1_rsp: got %b/%h want 10/44444444", rvalid, rdata[1]); end
    @(posedge clk); #1;
    req = 2'b00;
    @(negedge clk);
    n_cmp++; if (rvalid !== 2'b01) begin n_bad++; $display("FAIL stall_m0_rsp: got %b want 01", rvalid); end
    @(posedge clk); #1;
  endtask

  task automatic test_miss();
    poke(8'd0, 32'h5A5A_5A5A);
    do_reset();
    req = 2'b10; we[1] = 1'b1; be[1] = 4'hF; addr[1] = 32'h1000_0000; wdata[1] = 32'hDEAD_BEEF;
    @(negedge clk);
    n_cmp++; if (s_req !== 1'b0 || s_we !== 1'b0) begin n_bad++; $display("FAIL miss_s_req: got req %b we %b want 0/0", s_req, s_we); end
    n_cmp++; if (gnt !== 2'b10) begin n_bad++; $display("FAIL miss_gnt: got %b want 10", gnt); end
    @(posedge clk); #1;
    req = 2'b00;
    @(negedge clk);
    n_cmp++; if (rvalid !== 2'b10 || err !== 2'b10) begin n_bad++; $display("FAIL miss_rsp: got rvalid %b err %b want 10/10", rvalid, err); end
    n_cmp++; if (rdata[1] !== 32'h0) begin n_bad++; $display("FAIL miss_rdata: got %h want 0", rdata[1]); end
    @(posedge clk); #1;
    n_cmp++; if (sram_mem[0] !== 32'h5A5A_5A5A) begin n_bad++; $display("FAIL miss_sram: got %h want 5a5a5a5a", sram_mem[0]); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    req = 2'b01; we[0] = 1'b0; addr[0] = 32'h8000_0004;
    @(negedge clk);
    n_cmp++; if (gnt !== 2'b01) begin n_bad++; $display("FAIL midrst_gnt: got %b want 01", gnt); end
    @(posedge clk); #1;
    rst = 1'b1; req = 2'b00;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (rvalid !== 2'b00) begin n_bad++; $display("FAIL midrst_rvalid c%0d: got %b want 00", c, rvalid); end
      @(posedge clk); #1;
      rst = 1'b0;
    end
  endtask

  task automatic test_random();
    bit [31:0]   ref_mem [256];
    bit          act [2];
    int          lock_o, last, owner, p_owner;
    bit          p_valid, p_loc, p_err, hit, exp_sreq;
    logic [31:0] p_data, exp_d, a;
    logic [1:0]  eg, exp_rv, exp_er;
    do_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = sram_mem[i];
    lock_o = -1; last = 1; p_valid = 0; p_owner = 0; p_loc = 0; p_err = 0; p_data = 0;
    act[0] = 0; act[1] = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int m = 0; m < 2; m++) begin
        if (!act[m] && $urandom_range(0, 2) != 0) begin
          act[m] = 1;
          we[m] = 1'($urandom_range(0, 1));
          be[m] = 4'($urandom);
          wdata[m] = $urandom;
          case ($urandom_range(0, 5))
            0: a = 32'h801F_FFFC;
            1: a = 32'h8020_0000;
            2: a = 32'h7FFF_FFFC;
            3: begin a = $urandom; if (a >= 32'h8000_0000 && a <= 32'h801F_FFFF) a = a ^ 32'h4000_0000; end
            default: a = 32'h8000_0000 + 32'($urandom_range(0, 63) * 4) + ($urandom_range(0, 1) != 0 ? 32'h0010_0000 : 32'h0);
          endcase
          addr[m] = a;
        end
        req[m] = act[m];
      end
      s_gnt = ($urandom_range(0, 3) != 0);
      sram_err_next = ($urandom_range(0, 7) == 0);
      if (lock_o >= 0) owner = lock_o;
      else if (act[0] && act[1]) begin
`ifdef MEM_ARB_RR_EN
        owner = 1 - last;
`else
        owner = 0;
`endif
      end else if (act[0]) owner = 0;
      else if (act[1]) owner = 1;
      else owner = -1;
      eg = 2'b00; exp_sreq = 0; hit = 0;
      if (owner >= 0) begin
        hit = (addr[owner] >= 32'h8000_0000) && (addr[owner] <= 32'h801F_FFFF);
        exp_sreq = hit;
        if (!hit || s_gnt) eg[owner] = 1'b1;
      end
      @(negedge clk);
      n_cmp++; if (gnt !== eg) begin n_bad++; $display("FAIL rand_gnt cyc%0d: got %b want %b", cyc, gnt, eg); end
      n_cmp++; if (s_req !== exp_sreq) begin n_bad++; $display("FAIL rand_s_req cyc%0d: got %b want %b", cyc, s_req, exp_sreq); end
      if (exp_sreq) begin
        n_cmp++;
        if (s_addr !== addr[owner] || s_we !== we[owner] || s_be !== be[owner] || s_wdata !== wdata[owner]) begin
          n_bad++; $display("FAIL rand_payload cyc%0d: got %h/%b/%h/%h want %h/%b/%h/%h", cyc, s_addr, s_we, s_be, s_wdata, addr[owner], we[owner], be[owner], wdata[owner]);
        end
      end else begin
        n_cmp++; if (s_we !== 1'b0) begin n_bad++; $display("FAIL rand_s_we cyc%0d: got %b want 0", cyc, s_we); end
      end
      exp_rv = 2'b00; exp_er = 2'b00;
      if (p_valid) begin
        exp_rv[p_owner] = 1'b1;
        exp_er[p_owner] = p_loc || p_err;
      end
      n_cmp++; if (rvalid !== exp_rv) begin n_bad++; $display("FAIL rand_rvalid cyc%0d: got %b want %b", cyc, rvalid, exp_rv); end
      n_cmp++; if (err !== exp_er) begin n_bad++; $display("FAIL rand_err cyc%0d: got %b want %b", cyc, err, exp_er); end
      for (int m = 0; m < 2; m++) begin
        exp_d = (p_valid && p_owner == m && !p_loc) ? p_data : 32'h0;
        n_cmp++; if (rdata[m] !== exp_d) begin n_bad++; $display("FAIL rand_rdata m%0d cyc%0d: got %h want %h", m, cyc, rdata[m], exp_d); end
      end
      p_valid = 0;
      if (owner >= 0) begin
        if (hit && !s_gnt) lock_o = owner;
        else begin
          lock_o = -1; last = owner;
          p_valid = 1; p_owner = owner; p_loc = !hit; p_err = sram_err_next;
          p_data = ref_mem[addr[owner][9:2]];
          if (hit && we[owner]) begin
            for (int b = 0; b < 4; b++)
              if (be[owner][b]) ref_mem[addr[owner][9:2]][8*b +: 8] = wdata[owner][8*b +: 8];
          end
          act[owner] = 0;
        end
      end
      @(posedge clk); #1;
    end
    req = 2'b00;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; req = 2'b00; we = 2'b00; s_gnt = 1'b1; sram_err_next = 1'b0;
    be[0] = 4'hF; be[1] = 4'hF; addr[0] = 32'h0; addr[1] = 32'h0; wdata[0] = 32'h0; wdata[1] = 32'h0;
    poke_en = 1'b0; poke_idx = 8'h0; poke_val = 32'h0;
    @(posedge clk); #1;
    test_reset();
    test_read();
    test_contention();
    test_stall();
    test_miss();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
